bit_serial_addsub: RTL and testbench
====================================

Name: bit_serial_addsub

Overview:
- Multi-cycle add/subtract sequencer in alu_ops that sits directly upstream of the one-bit full adder `adder`.
- Feeds the adder one operand bit pair per cycle, LSB first, and keeps the carry in a flop between bits.
- Collects the sum bits into a WIDTH-bit result and produces carry, overflow and zero flags.
- Gives the CPU a small-area ALU add path; operands and result use valid/ready handshakes.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a, b, sub are valid.
- in_ready  output  1  block can accept a new operation.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  0 = a+b, 1 = a-b.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- carry_out  output  1  carry out of the MSB (for sub: 1 = no borrow, i.e. a >= b unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Asynchronous reset: state = IDLE; in_ready = 1; out_valid = 0; result = 0; carry_out = 0; overflow = 0; zero = 0; internal shift registers, carry flop and bit counter cleared.
- Reset asserted mid-operation aborts the operation; nothing partial is ever presented.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready at edge T: latch a into a_sh, latch (sub ? ~b : b) into b_sh, carry flop = sub, counter = 0, go to RUN.
  - RUN: in_ready = 0, out_valid = 0. Each cycle the adder sees a_sh[0], b_sh[0] and the carry flop. On the edge:
    - carry flop <= cout;
    - a_sh and b_sh shift right by 1;
    - result shift register shifts right, inserting s at the MSB;
    - counter increments.
  - On the edge where counter == WIDTH-1: capture the carry-in of the MSB bit (current carry flop) as c_msb and go to DONE.
  - DONE: out_valid = 1, in_ready = 0. result, carry_out (final carry flop), overflow (c_msb XOR final carry) and zero are stable. On out_valid && out_ready, go to IDLE at that edge.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge (32 cycles at default). Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- Outputs in DONE are registered or derived only from registers; there is no combinational path from a, b or sub to any output.
- in_valid is ignored outside IDLE. a, b and sub may change freely after acceptance.
- Backpressure: DONE holds all outputs unchanged for as many cycles as out_ready stays low.
- The counter uses $clog2(WIDTH) bits. In RUN it counts 0..WIDTH-1 with no wrap, because the FSM leaves RUN on the last value.
- result, carry_out, overflow and zero keep their last values in IDLE. Consumers must qualify them with out_valid.

Decomposition:
- Shared package alu_pkg:
  - state_t enum {IDLE, RUN, DONE};
  - localparam OP_ADD = 1'b0, OP_SUB = 1'b1.
- One sub-module instance: the existing one-bit full adder `adder`, instantiated once as the datapath bit slice. No other sub-modules.

Test Plan:
- Add: a=5, b=7, sub=0, out_ready=1 -> out_valid exactly 32 cycles after accept; result=12, carry_out=0, overflow=0, zero=0.
- Signed overflow: a=0x7FFFFFFF, b=1, add -> result=0x80000000, overflow=1, carry_out=0, zero=0.
- Unsigned wrap: a=0xFFFFFFFF, b=1, add -> result=0, carry_out=1, overflow=0, zero=1.
- Subtract: a=5, b=5 -> result=0, zero=1, carry_out=1. Then a=3, b=5 -> result=0xFFFFFFFE, carry_out=0, overflow=0.
- Backpressure and handshake:
  - hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout;
  - in_valid pulsed during RUN -> ignored;
  - release out_ready -> IDLE next cycle with in_ready=1.
- Reset mid-run: assert reset 10 cycles into RUN -> all outputs at reset values immediately (asynchronous). Next operation 1+2 -> result=3 after 32 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and operation codes.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder.sv
// One-bit full adder, used as the datapath bit slice of the serial ALU.
module adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_addsub.sv
// Bit-serial add/subtract sequencer: one operand bit pair per cycle, LSB first,
// through a single full-adder slice, with carry/overflow/zero flags.
module bit_serial_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   res_sh;
   logic [WIDTH-1:0]   res_next;
   logic [CNT_W-1:0]   cnt;
   logic               carry_q;
   logic               s;
   logic               cout;

   adder u_adder (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry_q),
      .s    (s),
      .cout (cout)
   );

   assign res_next = {s, res_sh[WIDTH-1:1]};
   assign result   = res_sh;

   // Handshakes: an operation transfers on the edge where in_valid && in_ready;
   // a result transfers on the edge where out_valid && out_ready. Both ready/valid
   // flags come straight from flops, so no input reaches an output combinationally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         res_sh    <= '0;
         cnt       <= '0;
         carry_q   <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
                  a_sh     <= a;
                  b_sh     <= (sub == OP_SUB) ? ~b : b;
                  carry_q  <= sub;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               carry_q <= cout;
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               res_sh  <= res_next;
               if (cnt == CNT_LAST) begin
                  // carry_q here is the carry into the MSB, cout the carry out of it.
                  carry_out <= cout;
                  overflow  <= carry_q ^ cout;
                  zero      <= (res_next == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Directed self-checking bench for bit_serial_addsub at WIDTH = 32.
module tb_bit_serial_addsub;

   localparam int W = 32;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         zero;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [W-1:0] exp_q[$];

   bit_serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver: issue one operation from IDLE, scramble inputs after acceptance,
   // then wait (bounded) for out_valid and report the cycle count
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        output int lat);
      @(negedge clk);
      a        = av;
      b        = bv;
      sub      = sv;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = $urandom;
      b        = $urandom;
      sub      = 1'($urandom_range(0, 1));
      lat      = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({in_ready, out_valid, result, carry_out, overflow, zero} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
         tests_failed++;
         $display("FAIL reset_state: got rdy=%b vld=%b res=%h c=%b o=%b z=%b want rdy=1 vld=0 res=0 c=0 o=0 z=0",
                  in_ready, out_valid, result, carry_out, overflow, zero);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // vectors: {a, b, sub, result, carry, overflow, zero}
   task automatic test_arith();
      logic [W-1:0] va[6]   = '{32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd3, 32'h8000_0000};
      logic [W-1:0] vb[6]   = '{32'd7, 32'd1,         32'd1,         32'd5, 32'd5, 32'd1};
      logic         vs[6]   = '{1'b0,  1'b0,          1'b0,          1'b1,  1'b1,  1'b1};
      logic [W-1:0] vr[6]   = '{32'd12, 32'h8000_0000, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
      logic [2:0]   vf[6]   = '{3'b000, 3'b010,        3'b101, 3'b101, 3'b000,     3'b110};
      int lat;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(vr[i]);
         do_op(va[i], vb[i], vs[i], lat);
         tests_run++;
         if (lat !== W) begin
            tests_failed++;
            $display("FAIL arith_latency[%0d]: got %0d cycles want %0d", i, lat, W);
         end
         tests_run++;
         begin
            logic [W-1:0] er;
            er = exp_q.pop_front();
            if ({result, carry_out, overflow, zero} !== {er, vf[i]}) begin
               tests_failed++;
               $display("FAIL arith_value[%0d]: got res=%h cvz=%b%b%b want res=%h cvz=%b",
                        i, result, carry_out, overflow, zero, er, vf[i]);
            end
         end
         @(posedge clk);
         #1;
         tests_run++;
         if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("FAIL arith_idle[%0d]: got rdy=%b vld=%b want rdy=1 vld=0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      out_ready = 1'b0;
      @(negedge clk);
      a        = 32'd10;
      b        = 32'd20;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat      = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
         if (lat == 5) begin
            tests_run++;
            if (in_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL run_in_ready: got %b want 0", in_ready);
            end
            in_valid = 1'b1;
            a        = 32'd1000;
            b        = 32'd1;
            sub      = 1'b1;
         end else if (lat == 6) begin
            in_valid = 1'b0;
         end
      end
      tests_run++;
      if (lat !== W) begin
         tests_failed++;
         $display("FAIL bp_latency: got %0d cycles want %0d", lat, W);
      end
      tests_run++;
      if ({result, carry_out, overflow, zero} !== {32'd30, 3'b000}) begin
         tests_failed++;
         $display("FAIL bp_value: got res=%h cvz=%b%b%b want res=0000001e cvz=000",
                  result, carry_out, overflow, zero);
      end
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         tests_run++;
         if ({in_ready, out_valid, result, carry_out, overflow, zero} !== {2'b01, 32'd30, 3'b000}) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b res=%h cvz=%b%b%b want rdy=0 vld=1 res=0000001e cvz=000",
                     i, in_ready, out_valid, result, carry_out, overflow, zero);
         end
      end
      in_valid = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      tests_run++;
      if ({in_ready, out_valid, result} !== {2'b10, 32'd30}) begin
         tests_failed++;
         $display("FAIL bp_release: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=0000001e",
                  in_ready, out_valid, result);
      end
   endtask

   task automatic test_back_to_back();
      int n1;
      int n2;
      out_ready = 1'b1;
      exp_q.push_back(32'd101);
      exp_q.push_back(32'd42);
      @(negedge clk);
      a        = 32'd100;
      b        = 32'd1;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      a   = 32'd50;
      b   = 32'd8;
      sub = 1'b1;
      n1  = 0;
      while (out_valid !== 1'b1 && n1 < 100) begin
         @(posedge clk);
         #1;
         n1++;
      end
      tests_run++;
      if (result !== exp_q[0] || n1 !== W) begin
         tests_failed++;
         $display("FAIL b2b_first: got res=%h after %0d cycles want res=%h after %0d", result, n1, exp_q[0], W);
      end
      void'(exp_q.pop_front());
      n2 = 0;
      do begin
         @(posedge clk);
         #1;
         n2++;
      end while (out_valid !== 1'b1 && n2 < 100);
      in_valid = 1'b0;
      tests_run++;
      if (result !== exp_q[0] || carry_out !== 1'b1 || n2 !== W + 2) begin
         tests_failed++;
         $display("FAIL b2b_second: got res=%h c=%b spacing %0d want res=%h c=1 spacing %0d",
                  result, carry_out, n2, exp_q[0], W + 2);
      end
      void'(exp_q.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_run();
      int lat;
      out_ready = 1'b1;
      @(negedge clk);
      a        = 32'h1234_5678;
      b        = 32'h1111_1111;
      sub      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if ({in_ready, out_valid, result, carry_out, overflow, zero} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
         tests_failed++;
         $display("FAIL midrun_reset: got rdy=%b vld=%b res=%h c=%b o=%b z=%b want rdy=1 vld=0 res=0 c=0 o=0 z=0",
                  in_ready, out_valid, result, carry_out, overflow, zero);
      end
      @(negedge clk);
      reset = 1'b0;
      do_op(32'd1, 32'd2, 1'b0, lat);
      tests_run++;
      if (lat !== W || {result, carry_out, overflow, zero} !== {32'd3, 3'b000}) begin
         tests_failed++;
         $display("FAIL post_reset_op: got res=%h cvz=%b%b%b after %0d cycles want res=00000003 cvz=000 after %0d",
                  result, carry_out, overflow, zero, lat, W);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
